// File: rtl/cam_frame_reader.sv
// rtl/cam_frame_reader.sv - frame-buffer read addressing and 3-cycle pixel/sync realignment for VGA output
//
// Turns the VGA driver's pixel position into a frame-buffer read address for a
// CAM_SCREEN_X x CAM_SCREEN_Y capture, shown either as a 1x top-left window or
// as a 4x upscale. It then lines up the returned pixel with the delayed syncs.
//
// Ports:
//   clk, rst              pixel clock (shared with the frame-buffer read port), async active-high reset
//   vga_posX, vga_posY    current pixel position from the VGA driver
//   hsync_n_in/vsync_n_in syncs from the VGA driver, active low
//   scale_sel             0 = 1x window, 1 = 4x upscale; taken only at the start of a frame
//   mem_addr / mem_data   frame-buffer read port; data returns one cycle after the address
//   pixel_out             pixel to the VGA pins
//   hsync_n_out/vsync_n_out syncs delayed to match pixel_out
//   frame_start           one-cycle pulse where vsync_n_out falls
module cam_frame_reader #(
    parameter int              CAM_SCREEN_X = 160,
    parameter int              CAM_SCREEN_Y = 120,
    parameter int              AW           = 15,
    parameter int              DW           = 12,
    parameter int              H_ACTIVE     = 640,
    parameter int              V_ACTIVE     = 480,
    parameter logic [DW-1:0]   BORDER_COLOR = 12'h000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    vga_posX,
    input  logic [9:0]    vga_posY,
    input  logic          hsync_n_in,
    input  logic          vsync_n_in,
    input  logic          scale_sel,
    input  logic [DW-1:0] mem_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] pixel_out,
    output logic          hsync_n_out,
    output logic          vsync_n_out,
    output logic          frame_start
);

    localparam logic [9:0]    H_LIM      = 10'(H_ACTIVE);
    localparam logic [9:0]    V_LIM      = 10'(V_ACTIVE);
    localparam logic [9:0]    CX_LIM     = 10'(CAM_SCREEN_X);
    localparam logic [9:0]    CY_LIM     = 10'(CAM_SCREEN_Y);
    // One slot past the image, kept black, so every non-image read is harmless.
    localparam logic [AW-1:0] BLACK_ADDR = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);

    // ------------------------------------------------------------------
    // Mode latch: the scale only changes at the vsync falling edge so a
    // frame is never drawn half in one mode and half in the other.
    // ------------------------------------------------------------------
    logic vs_prev;
    logic mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev <= 1'b1;
            mode    <= 1'b0;
        end else begin
            vs_prev <= vsync_n_in;
            if (vs_prev && !vsync_n_in)
                mode <= scale_sel;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 combinational: source coordinates and window test
    // ------------------------------------------------------------------
    logic          active;
    logic          inwin;
    logic [9:0]    sx;
    logic [9:0]    sy;
    logic [AW-1:0] row_base;
    logic [AW-1:0] addr_calc;

    always_comb begin
        active = (vga_posX < H_LIM) && (vga_posY < V_LIM);
        if (mode) begin
            sx    = {2'b00, vga_posX[9:2]};
            sy    = {2'b00, vga_posY[9:2]};
            inwin = active;
        end else begin
            sx    = vga_posX;
            sy    = vga_posY;
            inwin = active && (vga_posX < CX_LIM) && (vga_posY < CY_LIM);
        end
    end

    // sy*160 as two shifts and an add keeps a multiplier out of the address path.
    generate
        if (CAM_SCREEN_X == 160) begin : g_row_160
            assign row_base = (AW'(sy) << 7) + (AW'(sy) << 5);
        end else begin : g_row_generic
            assign row_base = AW'(32'(sy) * CAM_SCREEN_X);
        end
    endgenerate

    assign addr_calc = row_base + AW'(sx);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic s1_active, s1_inwin, s1_hs, s1_vs;
    logic s2_active, s2_inwin, s2_hs, s2_vs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr    <= BLACK_ADDR;
            s1_active   <= 1'b0;
            s1_inwin    <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s2_active   <= 1'b0;
            s2_inwin    <= 1'b0;
            s2_hs       <= 1'b1;
            s2_vs       <= 1'b1;
            pixel_out   <= '0;
            hsync_n_out <= 1'b1;
            vsync_n_out <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            // Stage 1: address issued to the frame buffer
            mem_addr  <= inwin ? addr_calc : BLACK_ADDR;
            s1_active <= active;
            s1_inwin  <= inwin;
            s1_hs     <= hsync_n_in;
            s1_vs     <= vsync_n_in;

            // Stage 2: frame buffer is returning data for stage 1's address
            s2_active <= s1_active;
            s2_inwin  <= s1_inwin;
            s2_hs     <= s1_hs;
            s2_vs     <= s1_vs;

            // Stage 3: output register
            if (s2_inwin)
                pixel_out <= mem_data;
            else if (s2_active)
                pixel_out <= BORDER_COLOR;
            else
                pixel_out <= '0;
            hsync_n_out <= s2_hs;
            vsync_n_out <= s2_vs;
            // High exactly when vsync_n_out is about to go 1->0.
            frame_start <= vsync_n_out & ~s2_vs;
        end
    end

endmodule

// File: tb/tb_cam_frame_reader.sv
// tb/tb_cam_frame_reader.sv - directed self-checking bench for cam_frame_reader
module tb_cam_frame_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  vga_posX;
    logic [9:0]  vga_posY;
    logic        hsync_n_in;
    logic        vsync_n_in;
    logic        scale_sel;
    logic [11:0] mem_data;
    logic [14:0] mem_addr;
    logic [11:0] pixel_out;
    logic        hsync_n_out;
    logic        vsync_n_out;
    logic        frame_start;

    // Frame-buffer stand-in: fixed word, or a registered read whose data is addr[11:0]^12'h5A5.
    logic        fixed_en;
    logic [11:0] fixed_val;
    logic [14:0] mem_q;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    always @(posedge clk) mem_q <= mem_addr;
    assign mem_data = fixed_en ? fixed_val : (mem_q[11:0] ^ 12'h5A5);

    cam_frame_reader #(
        .BORDER_COLOR (12'h0F0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vga_posX    (vga_posX),
        .vga_posY    (vga_posY),
        .hsync_n_in  (hsync_n_in),
        .vsync_n_in  (vsync_n_in),
        .scale_sel   (scale_sel),
        .mem_data    (mem_data),
        .mem_addr    (mem_addr),
        .pixel_out   (pixel_out),
        .hsync_n_out (hsync_n_out),
        .vsync_n_out (vsync_n_out),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one position for a single cycle between blanking positions, then
    // check the address one cycle later and the pixel exactly three cycles later.
    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [14:0] ea, input logic [11:0] ep);
        vga_posX = x;
        vga_posY = y;
        @(negedge clk);
        check({tag, " addr"}, 32'(mem_addr), 32'(ea));
        vga_posX = 10'd700;
        vga_posY = 10'd0;
        @(negedge clk);
        check({tag, " pre"}, 32'(pixel_out), 32'h0);
        @(negedge clk);
        check({tag, " pix"}, 32'(pixel_out), 32'(ep));
    endtask

    // Two-cycle vsync pulse carrying a mode request; scale_sel flips afterwards.
    task automatic vsync_pulse(input logic sel);
        scale_sel  = sel;
        vsync_n_in = 1'b0;
        @(negedge clk);
        check("vs lag1", 32'(vsync_n_out), 32'h1);
        @(negedge clk);
        check("vs lag2", 32'(vsync_n_out), 32'h1);
        check("fs early", 32'(frame_start), 32'h0);
        vsync_n_in = 1'b1;
        scale_sel  = ~sel;
        @(negedge clk);
        check("vs out low", 32'(vsync_n_out), 32'h0);
        check("fs pulse", 32'(frame_start), 32'h1);
        @(negedge clk);
        check("vs out low2", 32'(vsync_n_out), 32'h0);
        check("fs one cycle", 32'(frame_start), 32'h0);
        @(negedge clk);
        check("vs out high", 32'(vsync_n_out), 32'h1);
        check("fs after", 32'(frame_start), 32'h0);
    endtask

    logic [7:0] pat;
    logic       hs_exp;

    initial begin
        vga_posX   = 10'd700;
        vga_posY   = 10'd0;
        hsync_n_in = 1'b1;
        vsync_n_in = 1'b1;
        scale_sel  = 1'b0;
        fixed_en   = 1'b1;
        fixed_val  = 12'hABC;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst addr", 32'(mem_addr), 32'd19200);
        check("rst pixel", 32'(pixel_out), 32'h0);
        check("rst hs", 32'(hsync_n_out), 32'h1);
        check("rst vs", 32'(vsync_n_out), 32'h1);
        check("rst fs", 32'(frame_start), 32'h0);

        // First pixel after release, fixed memory word
        rst = 1'b0;
        pix("origin", 10'd0, 10'd0, 15'd0, 12'hABC);

        // Mode 0 window edges, address-dependent memory data
        fixed_en = 1'b0;
        pix("m0 159,119", 10'd159, 10'd119, 15'd19199, 12'hF5A);
        pix("m0 160,0",   10'd160, 10'd0,   15'd19200, 12'h0F0);
        pix("m0 0,120",   10'd0,   10'd120, 15'd19200, 12'h0F0);

        // Switch to 4x; scale_sel drops back to 0 mid-frame
        vsync_pulse(1'b1);
        pix("m1 7,9",     10'd7,   10'd9,   15'd321,   12'h4E4);
        pix("m1 639,479", 10'd639, 10'd479, 15'd19199, 12'hF5A);
        pix("m1 midframe",10'd100, 10'd50,  15'd1945,  12'h23C);
        pix("m1 640,0",   10'd640, 10'd0,   15'd19200, 12'h000);

        // Next frame returns to 1x
        vsync_pulse(1'b0);
        pix("m0 100,50",  10'd100, 10'd50,  15'd8100,  12'hA01);
        pix("m0 7,9",     10'd7,   10'd9,   15'd1447,  12'h002);

        // Blanking with an all-ones memory word
        fixed_en  = 1'b1;
        fixed_val = 12'hFFF;
        pix("blank x700", 10'd700, 10'd0,   15'd19200, 12'h000);
        pix("blank y480", 10'd300, 10'd480, 15'd19200, 12'h000);

        // hsync pattern reproduced three cycles later
        pat = 8'b1011_0001;
        for (int i = 0; i < 11; i++) begin
            hsync_n_in = (i < 8) ? pat[i] : 1'b1;
            @(negedge clk);
            hs_exp = ((i - 2) >= 0 && (i - 2) < 8) ? pat[i - 2] : 1'b1;
            check("hsync shift", 32'(hsync_n_out), 32'(hs_exp));
        end

        // Reset mid-line
        fixed_en   = 1'b0;
        vga_posX   = 10'd5;
        vga_posY   = 10'd1;
        hsync_n_in = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-rst addr", 32'(mem_addr), 32'd165);
        check("pre-rst pixel", 32'(pixel_out), 32'h500);
        check("pre-rst hs", 32'(hsync_n_out), 32'h0);
        #5 rst = 1'b1;
        #1;
        check("async addr", 32'(mem_addr), 32'd19200);
        check("async pixel", 32'(pixel_out), 32'h0);
        check("async hs", 32'(hsync_n_out), 32'h1);
        check("async vs", 32'(vsync_n_out), 32'h1);
        check("async fs", 32'(frame_start), 32'h0);
        hsync_n_in = 1'b1;
        vga_posX   = 10'd300;
        vga_posY   = 10'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pix("refill", 10'd5, 10'd1, 15'd165, 12'h500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_frame_reader.md
Name: cam_frame_reader

Overview:
- Read-side stage between the dual-port frame buffer and the VGA output pins.
- Converts the VGA driver's pixel position into a frame-buffer read address for the 160x120 RGB444 capture, in either 1x (top-left window) or 4x (full-screen upscale) mode.
- Re-aligns the returned pixel data with the VGA sync signals through a fixed 3-cycle pipeline, and forces blanking and out-of-window pixels to defined colours.

Parameters:
- CAM_SCREEN_X, 160, source image width in pixels
- CAM_SCREEN_Y, 120, source image height in pixels
- AW, 15, frame-buffer address width
- DW, 12, pixel width (RGB444)
- H_ACTIVE, 640, VGA active width
- V_ACTIVE, 480, VGA active height
- BORDER_COLOR, 12'h000, colour driven for active pixels outside the image window

Ports:
- clk  in  1  pixel clock, 25 MHz; same clock as the frame-buffer read port
- rst  in  1  asynchronous, active-high reset
- vga_posX  in  10  horizontal position from the VGA driver
- vga_posY  in  10  vertical position from the VGA driver
- hsync_n_in  in  1  horizontal sync from the VGA driver, active low
- vsync_n_in  in  1  vertical sync from the VGA driver, active low
- scale_sel  in  1  0 = 1x window, 1 = 4x upscale
- mem_data  in  DW  frame-buffer read data; 1-cycle registered latency after mem_addr
- mem_addr  out  AW  frame-buffer read address
- pixel_out  out  DW  pixel to the VGA pins
- hsync_n_out  out  1  delayed hsync
- vsync_n_out  out  1  delayed vsync
- frame_start  out  1  1-cycle pulse on the falling edge of vsync_n_out

Behaviour:
- Reset state (async, active-high):
  - mem_addr = CAM_SCREEN_X*CAM_SCREEN_Y (the black slot)
  - pixel_out = 0
  - hsync_n_out = 1, vsync_n_out = 1
  - frame_start = 0
  - mode register = 0, all pipeline flags = 0
- Mode latch:
  - scale_sel is sampled into the mode register only on the cycle where vsync_n_in goes 1->0 (previous-value register).
  - Mid-frame changes to scale_sel have no effect until the next frame.
- Stage 1 (registered, cycle N+1 after the position is presented):
  - active = (posX < H_ACTIVE) and (posY < V_ACTIVE).
  - Mode 0: sx = posX, sy = posY; inwin = active and posX < CAM_SCREEN_X and posY < CAM_SCREEN_Y.
  - Mode 1: sx = posX>>2, sy = posY>>2; inwin = active.
  - If inwin, mem_addr = sx + sy*CAM_SCREEN_X, computed as (sy<<7)+(sy<<5)+sx for the default width; there is no generic multiplier in the path. Otherwise mem_addr = CAM_SCREEN_X*CAM_SCREEN_Y.
  - active, inwin and both syncs are registered alongside the address.
- Stage 2: the frame buffer returns mem_data; active, inwin and the syncs are delayed one more cycle.
- Stage 3 (registered output):
  - pixel_out = mem_data if inwin; BORDER_COLOR if active and not inwin; 0 if not active.
  - hsync_n_out and vsync_n_out are the inputs delayed by exactly 3 cycles.
- Total latency: 3 clk cycles from position and syncs in to pixel_out and syncs out; it is constant and identical for every path.
- frame_start asserts on the cycle where vsync_n_out goes 1->0, and for that cycle only.
- Boundaries:
  - posX = 159 and 160 in mode 0 fall on opposite sides of the window edge.
  - Maximum address in mode 1 is at posX = 639, posY = 479 -> 119*160+159 = 19199.
  - Positions at or beyond 640/480 (blanking) never produce a valid image address.
- Reset asserted mid-line: all outputs return to reset values immediately. After release, the first valid pixel appears 3 cycles after the first sampled position.

Test Plan:
- Reset release, posX=0, posY=0, mode 0, mem_data tied to 12'hABC -> mem_addr=0 one cycle after sampling; pixel_out=12'hABC exactly 3 cycles after the position is applied; syncs=1 during reset.
- Mode 0 at posX=159, posY=119 -> mem_addr=19199; at posX=160, posY=0 -> mem_addr=19200 and pixel_out=BORDER_COLOR 3 cycles later.
- Mode 1 latched at vsync fall, posX=7, posY=9 -> mem_addr=1+2*160=321; posX=639, posY=479 -> 19199.
- Toggle scale_sel mid-frame, then sweep a full frame -> addressing stays in the old mode until the next vsync_n_in fall, then switches; the frame_start pulse is exactly 1 cycle wide and 3 cycles after the vsync_n_in fall.
- posX=700 (blanking) with mem_data=12'hFFF -> pixel_out=0; hsync pulse pattern on input is reproduced on output with a 3-cycle shift and no width change.
- Assert rst for 2 cycles mid-line at posX=300 -> outputs go to reset values asynchronously; after release the pipeline refills and the output is correct from cycle 3 onward.
